// File: rtl/mem_rr_arbiter_pkg.sv
// mem_arb_pkg: shared types and sizing helpers for the round-robin memory
// arbiter and its rotate-priority picker.
//   state_e    : arbiter FSM states (IDLE, BUSY)
//   idx_width  : width of a requester index for n requesters
//   cnt_width  : width of a watchdog counter that must hold 0..timeout
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_TIMEOUT = 16;
  localparam int GNT_W_DEFAULT   = idx_width(DEFAULT_NUM_REQ);
  localparam int CNT_W_DEFAULT   = cnt_width(DEFAULT_TIMEOUT);

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: bus between the arbiter and one single-port memory.
//   master (arbiter): mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o out;
//                     mem_rd_data_i, mem_ready_i in
//   slave  (memory) : the mirror image
// Handshake: the master raises mem_valid_o with stable fields and holds them
// unchanged until mem_ready_i; the slave pulses mem_ready_i for exactly one
// cycle per accepted transaction, with read data on mem_rd_data_i in that
// same cycle. A transfer happens in the cycle where valid and ready are both 1.
interface mem_rr_arbiter_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  mem_valid_o;
  logic                  mem_wr_rd_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0]      mem_wr_data_o;
  logic [WIDTH-1:0]      mem_rd_data_i;
  logic                  mem_ready_i;

  modport master (
    output mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o,
    input  mem_rd_data_i, mem_ready_i
  );

  modport slave (
    input  mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o,
    output mem_rd_data_i, mem_ready_i
  );
endinterface

// File: rtl/mem_rr_arbiter_pick.sv
// rr_arb_pick: combinational rotate-priority picker.
//   req_i  : pending request bits
//   last_i : index granted last; the search starts just after it
//   any_o  : at least one request pending
//   idx_o  : first pending index found scanning last_i+1, last_i+2, ... (mod N)
module rr_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   idx_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the nearest pending request
  // after last_i is the one left standing; no early exit needed.
  always_comb begin
    any_o    = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand     = (int'(last_i) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req_i[cand_idx]) begin
        any_o = 1'b1;
        idx_o = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: shares one single-port memory between NUM_REQ requesters
// with round-robin fairness and a watchdog that aborts stalled transactions.
//   clk, rst       : clock, asynchronous active-low reset
//   req_valid_i    : per-requester pending bit
//   req_wr_rd_i    : per-requester direction (1 = write)
//   req_addr_i     : flattened addresses, slot k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wr_data_i  : flattened write data, slot k at [k*WIDTH +: WIDTH]
//   req_ready_o    : one-hot completion pulse to the granted requester
//   rd_data_o      : read data, meaningful only with a req_ready_o pulse
//   err_o          : marks a completion pulse caused by watchdog abort
//   gnt_id_o       : granted requester index, meaningful in BUSY
//   state_o        : FSM state, for observation
//   mem_if         : master side of the memory bus
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  WIDTH      = 16,
  parameter int  DEPTH      = 64,
  parameter int  ADDR_WIDTH = $clog2(DEPTH),
  parameter int  NUM_REQ    = 4,
  parameter int  TIMEOUT    = 16,
  localparam int GNT_W      = idx_width(NUM_REQ),
  localparam int CNT_W      = cnt_width(TIMEOUT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_wr_rd_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wr_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [WIDTH-1:0]              rd_data_o,
  output logic                          err_o,
  output logic [GNT_W-1:0]              gnt_id_o,
  output state_e                        state_o,
  mem_rr_arbiter_if.master              mem_if
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2 || (2 ** ADDR_WIDTH) < DEPTH) begin : g_param_check
    $error("mem_rr_arbiter: unsupported parameter set");
  end

  state_e                state_q, state_d;
  logic [GNT_W-1:0]      gnt_q, gnt_d;
  logic [GNT_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_rd_q, wr_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;

  logic                  pick_any;
  logic [GNT_W-1:0]      pick_idx;
  logic                  timed_out;

  rr_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  // A ready in the last allowed cycle wins over the watchdog.
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1)) && !mem_if.mem_ready_i;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    wr_rd_d     = wr_rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_o = '0;
    rd_data_o   = '0;
    err_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          gnt_d   = pick_idx;
          wr_rd_d = req_wr_rd_i[pick_idx];
          addr_d  = req_addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wr_data_i[pick_idx*WIDTH +: WIDTH];
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (mem_if.mem_ready_i || timed_out) begin
          req_ready_o[gnt_q] = 1'b1;
          rd_data_o          = mem_if.mem_rd_data_i;
          err_o              = timed_out;
          last_d             = gnt_q;
          cnt_d              = '0;
          state_d            = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= GNT_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      wr_rd_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wr_rd_q <= wr_rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign gnt_id_o             = gnt_q;
  assign state_o              = state_q;
  assign mem_if.mem_valid_o   = (state_q == BUSY);
  assign mem_if.mem_wr_rd_o   = wr_rd_q;
  assign mem_if.mem_addr_o    = addr_q;
  assign mem_if.mem_wr_data_o = wdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;
  import mem_arb_pkg::*;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 64;
  localparam int AW      = 6;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int GW      = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_wr_rd;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      rd_data;
  logic                  err;
  logic [GW-1:0]         gnt_id;
  state_e                state;

  mem_rr_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) mif ();

  mem_rr_arbiter #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_REQ(NREQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_wr_rd_i   (req_wr_rd),
    .req_addr_i    (req_addr),
    .req_wr_data_i (req_wdata),
    .req_ready_o   (req_ready),
    .rd_data_o     (rd_data),
    .err_o         (err),
    .gnt_id_o      (gnt_id),
    .state_o       (state),
    .mem_if        (mif.master)
  );

  // ---------------- memory model ----------------
  logic [WIDTH-1:0] mem_arr [DEPTH];
  int  mem_lat   = 0;
  bit  mem_stall = 1'b0;
  int  lat_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mif.mem_ready_i   <= 1'b0;
      mif.mem_rd_data_i <= '0;
      lat_cnt           <= 0;
    end else begin
      mif.mem_ready_i <= 1'b0;
      if (!mif.mem_valid_o) begin
        lat_cnt <= 0;
      end else if (!mif.mem_ready_i && !mem_stall) begin
        if (lat_cnt >= mem_lat) begin
          mif.mem_ready_i <= 1'b1;
          lat_cnt         <= 0;
          if (mif.mem_wr_rd_o) mem_arr[mif.mem_addr_o] <= mif.mem_wr_data_o;
          else                 mif.mem_rd_data_i <= mem_arr[mif.mem_addr_o];
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [GW-1:0]    exp_q[$];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  bit               ref_ok  [DEPTH];
  int               wait_cnt[NREQ];
  int               model_last;
  int               cur_id;
  logic             prev_mv;
  int               grp_order[NREQ];
  int               grp_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Round-robin rule: first pending requester after the last one served.
  function automatic int model_pick(input logic [NREQ-1:0] p, input int last);
    int j;
    for (int i = 1; i <= NREQ; i++) begin
      j = (last + i) % NREQ;
      if (p[j]) return j;
    end
    return -1;
  endfunction

  function automatic int onehot_to_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input bit wr, input int addr, input logic [WIDTH-1:0] data);
    req_wr_rd[id]                = wr;
    req_addr[id*AW +: AW]        = AW'(addr);
    req_wdata[id*WIDTH +: WIDTH] = data;
  endtask

  task automatic do_txn(input int id, input bit wr, input int addr, input logic [WIDTH-1:0] data,
                        input int lat, input bit chk_rd, input logic [WIDTH-1:0] exp_rd);
    int n;
    logic [NREQ-1:0] rdy;
    mem_lat = lat;
    @(posedge clk); #1;
    set_req(id, wr, addr, data);
    req_valid[id] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("txn_valid_rise", 32'(mif.mem_valid_o), 1);
    chk("txn_gnt_id", 32'(gnt_id), 32'(id));
    chk("txn_mem_addr", 32'(mif.mem_addr_o), 32'(addr));
    chk("txn_mem_wr_rd", 32'(mif.mem_wr_rd_o), 32'(wr));
    if (wr) chk("txn_mem_wr_data", 32'(mif.mem_wr_data_o), 32'(data));
    n   = 1;
    rdy = req_ready;
    while (rdy == 0 && n < 60) begin
      @(negedge clk);
      n++;
      rdy = req_ready;
    end
    chk("txn_ready_onehot", 32'(rdy), 32'(1) << id);
    chk("txn_latency", 32'(n), 32'(lat + 2));
    chk("txn_err", 32'(err), 0);
    if (chk_rd) chk("txn_rd_data", 32'(rd_data), 32'(exp_rd));
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  // Raise several requests at once (fields preset) and record completion order.
  task automatic run_group(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] d;
    grp_n = 0;
    for (int i = 0; i < NREQ; i++) grp_order[i] = -1;
    @(posedge clk); #1;
    req_valid = mask;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      d = req_ready;
      if (d != 0) begin
        if (grp_n < NREQ) grp_order[grp_n] = onehot_to_idx(d);
        grp_n++;
        @(posedge clk); #1;
        req_valid = req_valid & ~d;
        if (req_valid == 0) break;
      end
    end
    chk("grp_drained", 32'(req_valid), 0);
    req_valid = '0;
  endtask

  // One observation step of the random phase, run at each falling edge.
  task automatic monitor_step();
    logic [GW-1:0] e;
    int a;
    if (mif.mem_valid_o && !prev_mv) begin
      if (exp_q.size() == 0) begin
        chk("rand_unexpected_grant", 1, 0);
      end else begin
        e      = exp_q.pop_front();
        cur_id = int'(e);
        chk("rand_gnt", 32'(gnt_id), 32'(e));
        chk("rand_mem_addr", 32'(mif.mem_addr_o), 32'(req_addr[cur_id*AW +: AW]));
        chk("rand_mem_wr_rd", 32'(mif.mem_wr_rd_o), 32'(req_wr_rd[cur_id]));
      end
    end
    if (req_ready != 0) begin
      chk("rand_ready", 32'(req_ready), 32'(1) << cur_id);
      chk("rand_err", 32'(err), 0);
      chk("rand_fair", 32'(wait_cnt[cur_id] <= NREQ - 1), 1);
      a = int'(req_addr[cur_id*AW +: AW]);
      if (req_wr_rd[cur_id]) begin
        ref_mem[a] = req_wdata[cur_id*WIDTH +: WIDTH];
        ref_ok[a]  = 1'b1;
      end else if (ref_ok[a]) begin
        chk("rand_rd_data", 32'(rd_data), 32'(ref_mem[a]));
      end
      for (int k = 0; k < NREQ; k++) if (k != cur_id && req_valid[k]) wait_cnt[k]++;
      wait_cnt[cur_id] = 0;
      model_last       = cur_id;
    end
    if (!mif.mem_valid_o && req_valid != 0) exp_q.push_back(GW'(model_pick(req_valid, model_last)));
    prev_mv = mif.mem_valid_o;
  endtask

  task automatic rand_phase(input int ncyc);
    logic [NREQ-1:0] done;
    for (int c = 0; c < ncyc + 300; c++) begin
      @(negedge clk);
      monitor_step();
      done = req_ready;
      if (c >= ncyc && req_valid == 0 && !mif.mem_valid_o) break;
      @(posedge clk); #1;
      for (int k = 0; k < NREQ; k++) begin
        if (done[k]) req_valid[k] = 1'b0;
        if (c < ncyc && !req_valid[k] && $urandom_range(0, 2) == 0) begin
          set_req(k, 1'($urandom_range(0, 1)), int'($urandom_range(8, 15)), WIDTH'($urandom));
          req_valid[k] = 1'b1;
        end
      end
      if (done != 0) mem_lat = int'($urandom_range(0, 4));
    end
    chk("rand_drained", 32'(req_valid), 0);
    chk("rand_exp_q_empty", 32'(exp_q.size()), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int               id;
    bit               wr;
    int               addr;
    logic [WIDTH-1:0] data;
    int               lat;
    bit               chk_rd;
    logic [WIDTH-1:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    vecs[0] = '{0, 1'b1, 5,  16'hBEEF, 0, 1'b0, 16'h0000};
    vecs[1] = '{0, 1'b0, 5,  16'h0000, 0, 1'b1, 16'hBEEF};
    vecs[2] = '{1, 1'b1, 63, 16'h1234, 2, 1'b0, 16'h0000};
    vecs[3] = '{2, 1'b1, 0,  16'hFFFF, 1, 1'b0, 16'h0000};
    vecs[4] = '{2, 1'b0, 0,  16'h0000, 3, 1'b1, 16'hFFFF};
    vecs[5] = '{3, 1'b0, 63, 16'h0000, 0, 1'b1, 16'h1234};

    req_valid = '0;
    req_wr_rd = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_ok[i] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_mem_valid", 32'(mif.mem_valid_o), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_idle", 32'(state), 32'(IDLE));

    // Single transactions from the table
    for (int i = 0; i < 6; i++)
      do_txn(vecs[i].id, vecs[i].wr, vecs[i].addr, vecs[i].data,
             vecs[i].lat, vecs[i].chk_rd, vecs[i].exp_rd);

    // Contention: all four write addr k with 0x1000+k
    mem_lat = 0;
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, k, WIDTH'(16'h1000 + k));
    run_group(4'b1111);
    chk("cont_count", 32'(grp_n), 4);
    for (int k = 0; k < NREQ; k++) chk("cont_order", 32'(grp_order[k]), 32'(k));
    for (int k = 0; k < NREQ; k++) do_txn(1, 1'b0, k, '0, 1, 1'b1, WIDTH'(16'h1000 + k));

    // Pointer: req2 completes, then req0 and req3 together -> req3 first
    do_txn(2, 1'b1, 30, 16'h2222, 0, 1'b0, '0);
    set_req(0, 1'b0, 0, '0);
    set_req(3, 1'b0, 3, '0);
    run_group(4'b1001);
    chk("ptr_first", 32'(grp_order[0]), 3);
    chk("ptr_second", 32'(grp_order[1]), 0);

    // Timeout: memory never ready
    mem_stall = 1'b1;
    @(posedge clk); #1;
    set_req(1, 1'b1, 20, 16'hDEAD);
    req_valid[1] = 1'b1;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mif.mem_valid_o) n++;
      if (req_ready != 0) break;
    end
    chk("to_cycles", 32'(n), 32'(TIMEOUT));
    chk("to_ready", 32'(req_ready), 32'h2);
    chk("to_err", 32'(err), 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    mem_stall    = 1'b0;
    @(negedge clk);
    chk("to_back_idle", 32'(state), 32'(IDLE));
    chk("to_valid_low", 32'(mif.mem_valid_o), 0);
    do_txn(3, 1'b0, 5, '0, 0, 1'b1, 16'hBEEF);

    // Reset in the middle of BUSY
    mem_lat = 10;
    @(posedge clk); #1;
    set_req(2, 1'b1, 40, 16'h5A5A);
    req_valid[2] = 1'b1;
    n = 0;
    while (!mif.mem_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_busy_reached", 32'(mif.mem_valid_o), 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 32'(IDLE));
    chk("mid_rst_mem_valid", 32'(mif.mem_valid_o), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_rd_data", 32'(rd_data), 0);
    chk("mid_rst_gnt_id", 32'(gnt_id), 0);
    chk("mid_rst_mem_addr", 32'(mif.mem_addr_o), 0);
    chk("mid_rst_mem_wdata", 32'(mif.mem_wr_data_o), 0);
    req_valid = '0;
    mem_lat   = 0;
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b0, 0, '0);
    set_req(3, 1'b0, 1, '0);
    run_group(4'b1001);
    chk("post_rst_first", 32'(grp_order[0]), 0);
    chk("post_rst_second", 32'(grp_order[1]), 3);

    // Random phase against the reference model, from a fresh reset
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst        = 1'b1;
    model_last = NREQ - 1;
    prev_mv    = 1'b0;
    cur_id     = 0;
    exp_q.delete();
    for (int k = 0; k < NREQ; k++) wait_cnt[k] = 0;
    rand_phase(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
